// File: rtl/crc8_stream_if.sv
// ============================================================================
// Module   : crc8_stream_if
// Brief    : Framed byte-stream bundle (input stream, output stream, status)
//            for the CRC8 stream controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface crc8_stream_if #(
    parameter int CNT_W = 16
);
    logic             mode;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic             done;
    logic [7:0]       crc_value;
    logic             crc_ok;
    logic [CNT_W-1:0] byte_cnt;

    // Controller side
    modport master (
        input  mode, s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last, done, crc_value, crc_ok, byte_cnt
    );

    // Source / sink side
    modport slave (
        output mode, s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last, done, crc_value, crc_ok, byte_cnt
    );
endinterface

`default_nettype wire

// File: rtl/crc8_stream_ctrl.sv
// ============================================================================
// Module   : crc8_stream_ctrl
// Brief    : Frame controller around a CRC8 (poly 0x07) byte engine; appends
//            the CRC in generate mode, verifies the trailing byte in check mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc8_stream_ctrl #(
    parameter logic [7:0] CRC_INIT   = 8'h00,
    parameter logic [7:0] CRC_XOROUT = 8'h00,
    parameter int         CNT_W      = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    crc8_stream_if.master      bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BODY   = 2'd1,
        ST_APPEND = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic             r_mode;
    logic [7:0]       r_crc;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_done;
    logic [7:0]       r_crc_value;
    logic             r_crc_ok;
    logic [CNT_W-1:0] r_byte_cnt;

    logic             w_out_free;
    logic             w_s_ready;
    logic             w_accept;
    logic             w_mode;
    logic             w_idle;
    logic             w_fold;
    logic             w_drain_exit;
    logic [7:0]       w_crc_base;
    logic [CNT_W-1:0] w_cnt_base;
    logic [7:0]       w_crc_final;

    assign w_out_free   = !r_m_valid || bus.m_ready;
    assign w_idle       = (r_state == ST_IDLE);
    assign w_s_ready    = (w_idle || (r_state == ST_BODY)) && w_out_free;
    assign w_accept     = bus.s_valid && w_s_ready;
    assign w_mode       = w_idle ? bus.mode : r_mode;
    // The trailing byte of a check frame is the received CRC, not payload.
    assign w_fold       = !(bus.s_last && w_mode);
    assign w_drain_exit = (r_state == ST_DRAIN) && r_m_valid && bus.m_ready && r_m_last;
    assign w_crc_base   = w_idle ? CRC_INIT : r_crc;
    assign w_cnt_base   = w_idle ? '0 : r_cnt;
    assign w_crc_final  = r_crc ^ CRC_XOROUT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_BODY: begin
                if (w_accept) begin
                    if (bus.s_last) begin
                        w_state_next = w_mode ? ST_DRAIN : ST_APPEND;
                    end else begin
                        w_state_next = ST_BODY;
                    end
                end
            end
            ST_APPEND: begin
                if (w_out_free) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_exit) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode      <= 1'b0;
            r_crc       <= CRC_INIT;
            r_cnt       <= '0;
            r_m_data    <= 8'h00;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_done      <= 1'b0;
            r_crc_value <= 8'h00;
            r_crc_ok    <= 1'b0;
            r_byte_cnt  <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_m_data  <= bus.s_data;
                r_m_valid <= 1'b1;
                r_m_last  <= bus.s_last && w_mode;
                r_cnt     <= (w_cnt_base == c_cnt_max) ? w_cnt_base : w_cnt_base + 1'b1;
                if (w_fold) begin
                    r_crc <= crc8_byte(w_crc_base, bus.s_data);
                end else begin
                    r_crc <= w_crc_base;
                end
                if (w_idle) begin
                    r_mode <= bus.mode;
                end
            end else if ((r_state == ST_APPEND) && w_out_free) begin
                r_m_data  <= w_crc_final;
                r_m_valid <= 1'b1;
                r_m_last  <= 1'b1;
            end else if (r_m_valid && bus.m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            // In check mode the beat leaving DRAIN is the received CRC byte.
            if (w_drain_exit) begin
                r_done      <= 1'b1;
                r_crc_value <= w_crc_final;
                r_byte_cnt  <= r_cnt;
                r_crc_ok    <= r_mode ? (r_m_data == w_crc_final) : 1'b1;
                r_crc       <= CRC_INIT;
                r_cnt       <= '0;
            end
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.m_data    = r_m_data;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_last    = r_m_last;
    assign bus.done      = r_done;
    assign bus.crc_value = r_crc_value;
    assign bus.crc_ok    = r_crc_ok;
    assign bus.byte_cnt  = r_byte_cnt;

endmodule

`default_nettype wire
